// File: rtl/racket_ai_control.sv
// ---------------------------------------------------------------------------
// racket_ai_control
//
// Computer opponent for single-player mode. Once per frame it looks at the
// ball position and steers the left racket (player 2) toward the ball. The
// racket speed is limited and there is a dead band around the target. After
// the ball turns toward the AI there is a reaction delay. When the ball sits
// parked on the serve spot long enough, the block issues a one-clock serve
// request.
//
// Ports:
//   clk65MHz         in   1   system clock
//   rst_n            in   1   asynchronous active-low reset
//   ai_enable        in   1   single-player screen active; AI owns player 2
//   end_of_frame     in   1   one-cycle pulse per frame; the only update slot
//   x_pos_of_ball    in  11   ball top-left x
//   y_pos_of_ball    in  11   ball top-left y
//   pos_of_player_2  out 10   racket top y
//   serve_ai         out  1   one-clock serve request
//   tracking         out  1   high while the racket follows the ball
// ---------------------------------------------------------------------------
module racket_ai_control #(
  parameter int Y_MIN        = 51,
  parameter int Y_MAX        = 637,
  parameter int RACKET_H     = 80,
  parameter int BALL_SIZE    = 15,
  parameter int HOME_Y       = 344,
  parameter int STEP         = 2,
  parameter int DEADBAND     = 4,
  parameter int REACT_FRAMES = 8,
  parameter int SERVE_X      = 510,
  parameter int SERVE_Y      = 377,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk65MHz,
  input  logic        rst_n,
  input  logic        ai_enable,
  input  logic        end_of_frame,
  input  logic [10:0] x_pos_of_ball,
  input  logic [10:0] y_pos_of_ball,
  output logic [9:0]  pos_of_player_2,
  output logic        serve_ai,
  output logic        tracking
);

  // Counter widths sized so the counters can hold their terminal values.
  localparam int RW = $clog2(REACT_FRAMES + 1);
  localparam int PW = $clog2(SERVE_FRAMES + 1);

  // The racket is centred on the ball when its top sits this far above the
  // ball top: half a racket minus half a ball.
  localparam logic signed [11:0] TGT_OFS_S = 12'(RACKET_H / 2 - BALL_SIZE / 2);
  localparam logic signed [11:0] Y_MIN_S   = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
  localparam logic signed [11:0] HOME_S    = 12'(HOME_Y);
  localparam logic signed [11:0] STEP_S    = 12'(STEP);
  localparam logic signed [11:0] DEAD_S    = 12'(DEADBAND);

  typedef enum logic [1:0] {
    HOLD,
    CENTER,
    REACT,
    TRACK
  } state_t;

  state_t           state, state_d;
  logic [9:0]       pos, pos_d;
  logic [10:0]      x_prev, x_prev_d;
  logic             approaching, approaching_d;
  logic [RW-1:0]    react_cnt, react_d;
  logic [PW-1:0]    park_cnt, park_d;
  logic             serve_d;

  logic             approach_next;
  logic             parked;
  logic signed [11:0] y_s;
  logic signed [11:0] ball_raw;
  logic signed [11:0] ball_target;
  logic signed [11:0] target;
  logic signed [11:0] pos_s;
  logic signed [11:0] err;
  logic signed [11:0] abs_err;
  logic signed [11:0] step;
  logic signed [11:0] moved;
  logic [9:0]         move_pos;

  // Ball direction this frame. An unchanged x keeps the previous verdict,
  // so a ball that stalls horizontally does not flip the AI's state.
  always_comb begin
    approach_next = approaching;
    if (x_pos_of_ball < x_prev) begin
      approach_next = 1'b1;
    end else if (x_pos_of_ball > x_prev) begin
      approach_next = 1'b0;
    end
  end

  assign parked = (x_pos_of_ball == 11'(SERVE_X)) && (y_pos_of_ball == 11'(SERVE_Y));

  // Target and single-frame move. Everything is carried as 12-bit signed so
  // a ball near the top of the screen (y < 33) yields a negative raw target
  // that clamps to Y_MIN instead of wrapping to a huge value.
  always_comb begin
    y_s      = signed'({1'b0, y_pos_of_ball});
    ball_raw = y_s - TGT_OFS_S;

    ball_target = ball_raw;
    if (ball_raw < Y_MIN_S) begin
      ball_target = Y_MIN_S;
    end else if (ball_raw > Y_MAX_S) begin
      ball_target = Y_MAX_S;
    end

    target = (state == CENTER) ? HOME_S : ball_target;

    pos_s   = signed'({2'b00, pos});
    err     = target - pos_s;
    abs_err = (err < 0) ? -err : err;
    step    = (abs_err < STEP_S) ? abs_err : STEP_S;

    moved = pos_s;
    if (abs_err > DEAD_S) begin
      moved = (err < 0) ? (pos_s - step) : (pos_s + step);
    end

    if (moved < Y_MIN_S) begin
      move_pos = 10'(Y_MIN);
    end else if (moved > Y_MAX_S) begin
      move_pos = 10'(Y_MAX);
    end else begin
      move_pos = moved[9:0];
    end
  end

  // Next-state and datapath logic. Losing ai_enable overrides everything,
  // including a frame tick that arrives in the same cycle, so no move or
  // serve can leak out while the screen is being left.
  always_comb begin
    state_d       = state;
    pos_d         = pos;
    x_prev_d      = x_prev;
    approaching_d = approaching;
    react_d       = react_cnt;
    park_d        = park_cnt;
    serve_d       = 1'b0;

    if (end_of_frame) begin
      x_prev_d      = x_pos_of_ball;
      approaching_d = approach_next;
    end

    if (!ai_enable) begin
      state_d = HOLD;
      pos_d   = 10'(HOME_Y);
      react_d = '0;
      park_d  = '0;
    end else if (state == HOLD) begin
      pos_d   = 10'(HOME_Y);
      react_d = '0;
      park_d  = '0;
      if (end_of_frame) begin
        state_d = CENTER;
      end
    end else if (end_of_frame) begin
      // Park counter saturates so a long-parked ball serves only once;
      // any frame off the serve spot re-arms it.
      if (parked) begin
        if (park_cnt < PW'(SERVE_FRAMES)) begin
          park_d = park_cnt + PW'(1);
        end
        if (park_cnt == PW'(SERVE_FRAMES - 1)) begin
          serve_d = 1'b1;
        end
      end else begin
        park_d = '0;
      end

      case (state)
        CENTER: begin
          pos_d = move_pos;
          if (approach_next) begin
            state_d = REACT;
          end
        end
        REACT: begin
          if (!approach_next) begin
            state_d = CENTER;
            react_d = '0;
          end else if (react_cnt == RW'(REACT_FRAMES - 1)) begin
            state_d = TRACK;
            react_d = '0;
          end else begin
            react_d = react_cnt + RW'(1);
          end
        end
        TRACK: begin
          pos_d = move_pos;
          if (!approach_next) begin
            state_d = CENTER;
          end
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
    end else begin
      state <= state_d;
    end
  end

  // Datapath registers. serve_d defaults low, so serve_ai drops one clock
  // after the tick that raised it.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      pos         <= 10'(HOME_Y);
      x_prev      <= 11'(SERVE_X);
      approaching <= 1'b0;
      react_cnt   <= '0;
      park_cnt    <= '0;
      serve_ai    <= 1'b0;
    end else begin
      pos         <= pos_d;
      x_prev      <= x_prev_d;
      approaching <= approaching_d;
      react_cnt   <= react_d;
      park_cnt    <= park_d;
      serve_ai    <= serve_d;
    end
  end

  assign pos_of_player_2 = pos;
  assign tracking        = (state == TRACK);

endmodule

// File: tb/tb_racket_ai_control.sv
// ---------------------------------------------------------------------------
// tb_racket_ai_control
//
// Directed bench for racket_ai_control. Each frame tick pushes the expected
// racket position, serve request and tracking flag into a scoreboard; a
// monitor pops and compares right after every tick edge.
// ---------------------------------------------------------------------------
module tb_racket_ai_control;

  logic        clk65MHz = 1'b0;
  logic        rst_n;
  logic        ai_enable;
  logic        end_of_frame;
  logic [10:0] x_pos_of_ball;
  logic [10:0] y_pos_of_ball;
  logic [9:0]  pos_of_player_2;
  logic        serve_ai;
  logic        tracking;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] pos;
    logic       serve;
    logic       trk;
  } exp_t;

  exp_t  sb[$];
  string names[$];

  racket_ai_control dut (
    .clk65MHz        (clk65MHz),
    .rst_n           (rst_n),
    .ai_enable       (ai_enable),
    .end_of_frame    (end_of_frame),
    .x_pos_of_ball   (x_pos_of_ball),
    .y_pos_of_ball   (y_pos_of_ball),
    .pos_of_player_2 (pos_of_player_2),
    .serve_ai        (serve_ai),
    .tracking        (tracking)
  );

  always #5 clk65MHz = ~clk65MHz;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: tick cycle with the given inputs, then one idle cycle.
  task automatic applyStimulus(input int x, input int y, input logic en,
                               input int exp_pos, input logic exp_serve,
                               input logic exp_trk, input string name);
    exp_t e;
    @(negedge clk65MHz);
    x_pos_of_ball = 11'(x);
    y_pos_of_ball = 11'(y);
    ai_enable     = en;
    end_of_frame  = 1'b1;
    e.pos   = 10'(exp_pos);
    e.serve = exp_serve;
    e.trk   = exp_trk;
    sb.push_back(e);
    names.push_back(name);
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
  endtask

  // Monitor: compare outputs just after each tick edge; after an expected
  // serve, also confirm the request is gone one clock later.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk65MHz);
      if (end_of_frame === 1'b1 && rst_n === 1'b1) begin
        #1;
        if (sb.size() == 0) begin
          checkOutput("scoreboard_empty_on_tick", 1, 0);
        end else begin
          e = sb.pop_front();
          n = names.pop_front();
          checkOutput({n, ".pos"},      int'(pos_of_player_2), int'(e.pos));
          checkOutput({n, ".serve"},    int'(serve_ai),        int'(e.serve));
          checkOutput({n, ".tracking"}, int'(tracking),        int'(e.trk));
          if (e.serve) begin
            @(posedge clk65MHz);
            #1;
            checkOutput({n, ".serve_clear"}, int'(serve_ai), 0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n         = 1'b0;
    ai_enable     = 1'b0;
    end_of_frame  = 1'b0;
    x_pos_of_ball = 11'd510;
    y_pos_of_ball = 11'd377;

    repeat (3) @(negedge clk65MHz);
    checkOutput("reset.pos",      int'(pos_of_player_2), 344);
    checkOutput("reset.serve",    int'(serve_ai),        0);
    checkOutput("reset.tracking", int'(tracking),        0);
    @(negedge clk65MHz);
    rst_n = 1'b1;

    // HOLD with AI disabled, even with the ball parked.
    for (int i = 0; i < 10; i++) applyStimulus(510, 377, 1'b0, 344, 1'b0, 1'b0, "hold");

    // Enable tick leaves HOLD; parked frames count from the next tick.
    applyStimulus(510, 377, 1'b1, 344, 1'b0, 1'b0, "enable");
    for (int k = 1; k <= 60; k++) applyStimulus(510, 377, 1'b1, 344, (k == 60), 1'b0, "serve1");
    for (int k = 1; k <= 200; k++) applyStimulus(510, 377, 1'b1, 344, 1'b0, 1'b0, "no_reserve");

    // One frame off the spot re-arms; the return to x=510 is a leftward move,
    // so the AI also reacts and starts tracking after 8 REACT frames.
    applyStimulus(511, 377, 1'b1, 344, 1'b0, 1'b0, "unpark");
    for (int k = 1; k <= 60; k++) applyStimulus(510, 377, 1'b1, 344, (k == 60), (k >= 9), "serve2");

    // Ball recedes with target = 344: TRACK -> CENTER without moving.
    applyStimulus(520, 377, 1'b1, 344, 1'b0, 1'b0, "recede");

    // Reaction delay then tracking toward target 567, stopping at 564.
    for (int j = 1; j <= 125; j++)
      applyStimulus(520 - j, 600, 1'b1,
                    (j <= 9) ? 344 : min2(344 + 2 * (j - 9), 564),
                    1'b0, (j >= 9), "react_track");

    // Ball at top: raw target is negative, clamps to 51; stops at 54.
    for (int i = 1; i <= 260; i++)
      applyStimulus(395, 0, 1'b1, max2(564 - 2 * i, 54), 1'b0, 1'b1, "clamp_low");

    // Ball at bottom: target clamps to 637; stops at 634.
    for (int i = 1; i <= 295; i++)
      applyStimulus(395, 760, 1'b1, min2(54 + 2 * i, 634), 1'b0, 1'b1, "clamp_high");

    // Target 496 parks the racket at 500.
    for (int i = 1; i <= 70; i++)
      applyStimulus(395, 529, 1'b1, max2(634 - 2 * i, 500), 1'b0, 1'b1, "to_500");

    // Receding from 500: back to CENTER, drift down to 348 and hold.
    for (int r = 1; r <= 85; r++)
      applyStimulus(395 + r, 529, 1'b1, max2(500 - 2 * (r - 1), 348), 1'b0, 1'b0, "recede_center");

    // ai_enable drop off-tick forces HOLD on the next clock.
    @(negedge clk65MHz);
    ai_enable = 1'b0;
    @(posedge clk65MHz);
    #1;
    checkOutput("ai_drop.pos",      int'(pos_of_player_2), 344);
    checkOutput("ai_drop.tracking", int'(tracking),        0);
    applyStimulus(480, 529, 1'b1, 344, 1'b0, 1'b0, "reenable");

    // Back into TRACK, then two moving frames.
    for (int j = 1; j <= 9; j++) applyStimulus(480 - j, 377, 1'b1, 344, 1'b0, (j == 9), "react2");
    applyStimulus(470, 600, 1'b1, 346, 1'b0, 1'b1, "track2a");
    applyStimulus(469, 600, 1'b1, 348, 1'b0, 1'b1, "track2b");

    // Asynchronous reset away from any clock edge.
    @(negedge clk65MHz);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset.pos",      int'(pos_of_player_2), 344);
    checkOutput("async_reset.serve",    int'(serve_ai),        0);
    checkOutput("async_reset.tracking", int'(tracking),        0);
    @(negedge clk65MHz);
    rst_n         = 1'b1;
    x_pos_of_ball = 11'd510;
    y_pos_of_ball = 11'd377;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk65MHz);
      #1;
      checkOutput("post_reset_idle.pos",      int'(pos_of_player_2), 344);
      checkOutput("post_reset_idle.tracking", int'(tracking),        0);
    end
    applyStimulus(510, 377, 1'b1, 344, 1'b0, 1'b0, "post_reset_enable");

    // ai_enable falling on what would be the serve tick: no serve, and the
    // park count restarts after re-enabling.
    for (int k = 1; k <= 59; k++) applyStimulus(510, 377, 1'b1, 344, 1'b0, 1'b0, "park59");
    applyStimulus(510, 377, 1'b0, 344, 1'b0, 1'b0, "ai_fall");
    applyStimulus(510, 377, 1'b1, 344, 1'b0, 1'b0, "reenable2");
    for (int k = 1; k <= 60; k++) applyStimulus(510, 377, 1'b1, 344, (k == 60), 1'b0, "serve3");

    repeat (4) @(negedge clk65MHz);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
